// File: rtl/count_sampler.sv
`default_nettype none
// ============================================================================
// Module      : count_sampler
// Description : Periodic sampler for a free-running event counter. Every
//               PERIOD clocks the upstream count is captured and the delta
//               since the previous capture is computed, together with a
//               wrap-around flag. Each {wrap, delta} record is queued in a
//               small FIFO and offered on a valid/ready interface. Records
//               that arrive while the FIFO is full are dropped. Drops set a
//               sticky overflow flag and increment a saturating drop counter.
//
// Ports       : clk        - system clock, rising edge
//               rst        - synchronous reset, active low
//               count      - upstream counter value, sampled directly
//               enable     - 1 = sampling active
//               clear      - synchronous flush of FIFO, overflow, drop_count
//               out_valid  - FIFO non-empty
//               out_ready  - consumer accepts head entry
//               out_delta  - head entry delta
//               out_wrap   - head entry wrap flag
//               level      - FIFO occupancy
//               overflow   - sticky, set on first drop
//               drop_count - dropped records, saturates at 255
//               max_delta  - largest accepted delta (SAMPLER_MAXDELTA_EN only)
//
// Options     : `define SAMPLER_MAXDELTA_EN adds the max_delta output.
//
// Revision    : 1.0 - initial release
// ============================================================================
module count_sampler #(
    parameter int WIDTH  = 32,
    parameter int PERIOD = 16,
    parameter int DEPTH  = 4,
    parameter int LVLW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count,
    input  logic             enable,
    input  logic             clear,
`ifdef SAMPLER_MAXDELTA_EN
    output logic [WIDTH-1:0] max_delta,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_delta,
    output logic             out_wrap,
    output logic [LVLW-1:0]  level,
    output logic             overflow,
    output logic [7:0]       drop_count
);

    localparam int PCW  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0]      C_ST_IDLE  = 2'd0;
    localparam logic [1:0]      C_ST_PRIME = 2'd1;
    localparam logic [1:0]      C_ST_RUN   = 2'd2;
    localparam logic [PCW-1:0]  C_PLAST    = PCW'(PERIOD - 1);
    localparam logic [LVLW-1:0] C_FULL     = LVLW'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       state_q,      state_d;
    logic [PCW-1:0]   pcnt_q,       pcnt_d;
    logic [WIDTH-1:0] baseline_q,   baseline_d;
    logic [WIDTH:0]   mem_q [DEPTH];
    logic [WIDTH:0]   mem_d [DEPTH];
    logic [PTRW-1:0]  wr_ptr_q,     wr_ptr_d;
    logic [PTRW-1:0]  rd_ptr_q,     rd_ptr_d;
    logic [LVLW-1:0]  level_q,      level_d;
    logic             overflow_q,   overflow_d;
    logic [7:0]       drop_count_q, drop_count_d;
`ifdef SAMPLER_MAXDELTA_EN
    logic [WIDTH-1:0] max_delta_q,  max_delta_d;
`endif

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic             w_tick;
    logic             w_push_req;
    logic             w_pop;
    logic             w_full;
    logic             w_accept;
    logic             w_drop;
    logic [WIDTH-1:0] w_delta;
    logic             w_wrap;

    always_comb begin
        // Tick only while sampling stays enabled; a tick that coincides with
        // enable falling belongs to the discarded period.
        w_tick     = (state_q != C_ST_IDLE) && enable && (pcnt_q == C_PLAST);
        w_push_req = w_tick && (state_q == C_ST_RUN);
        w_pop      = (level_q != '0) && out_ready;
        w_full     = (level_q == C_FULL);
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        w_accept   = w_push_req && (!w_full || w_pop);
        w_drop     = w_push_req && w_full && !w_pop;
        w_delta    = count - baseline_q;
        w_wrap     = (count < baseline_q);
    end

    // ------------------------------------------------------------------
    // Sampling state machine, period counter and baseline
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pcnt_d     = pcnt_q;
        baseline_d = baseline_q;
        case (state_q)
            C_ST_IDLE: begin
                pcnt_d = '0;
                if (enable) begin
                    state_d = C_ST_PRIME;
                end
            end
            C_ST_PRIME, C_ST_RUN: begin
                if (!enable) begin
                    state_d = C_ST_IDLE;
                    pcnt_d  = '0;
                end else if (w_tick) begin
                    state_d    = C_ST_RUN;
                    pcnt_d     = '0;
                    baseline_d = count;
                end else begin
                    pcnt_d = pcnt_q + PCW'(1);
                end
            end
            default: begin
                state_d = C_ST_IDLE;
                pcnt_d  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO and drop accounting; clear takes precedence over push/pop
    // ------------------------------------------------------------------
    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
`ifdef SAMPLER_MAXDELTA_EN
        max_delta_d  = max_delta_q;
`endif
        if (clear) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            level_d      = '0;
            overflow_d   = 1'b0;
            drop_count_d = '0;
`ifdef SAMPLER_MAXDELTA_EN
            max_delta_d  = '0;
`endif
        end else begin
            if (w_accept) begin
                mem_d[wr_ptr_q] = {w_wrap, w_delta};
                wr_ptr_d        = wr_ptr_q + PTRW'(1);
`ifdef SAMPLER_MAXDELTA_EN
                if (w_delta > max_delta_q) begin
                    max_delta_d = w_delta;
                end
`endif
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PTRW'(1);
            end
            if (w_accept && !w_pop) begin
                level_d = level_q + LVLW'(1);
            end else if (w_pop && !w_accept) begin
                level_d = level_q - LVLW'(1);
            end
            if (w_drop) begin
                overflow_d = 1'b1;
                if (drop_count_q != 8'hFF) begin
                    drop_count_d = drop_count_q + 8'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= C_ST_IDLE;
            pcnt_q       <= '0;
            baseline_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
`ifdef SAMPLER_MAXDELTA_EN
            max_delta_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            pcnt_q       <= pcnt_d;
            baseline_q   <= baseline_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
`ifdef SAMPLER_MAXDELTA_EN
            max_delta_q  <= max_delta_d;
`endif
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk) begin
                if (!rst) begin
                    mem_q[gi] <= '0;
                end else begin
                    mem_q[gi] <= mem_d[gi];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs; head data is forced to zero while empty so stale entries
    // never show after reset or clear.
    // ------------------------------------------------------------------
    always_comb begin
        out_valid  = (level_q != '0);
        out_delta  = out_valid ? mem_q[rd_ptr_q][WIDTH-1:0] : '0;
        out_wrap   = out_valid ? mem_q[rd_ptr_q][WIDTH]     : 1'b0;
        level      = level_q;
        overflow   = overflow_q;
        drop_count = drop_count_q;
`ifdef SAMPLER_MAXDELTA_EN
        max_delta  = max_delta_q;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_count_sampler.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_sampler
// Description : Scoreboard bench for count_sampler. The stimulus process
//               queues hand-computed {wrap, delta} records; a monitor pops
//               and compares whenever the DUT hands over an entry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_sampler;

    localparam int WIDTH = 32;
    localparam int LVLW  = 3;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] count;
    logic             enable;
    logic             clear;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_delta;
    logic             out_wrap;
    logic [LVLW-1:0]  level;
    logic             overflow;
    logic [7:0]       drop_count;
`ifdef SAMPLER_MAXDELTA_EN
    logic [WIDTH-1:0] max_delta;
`endif

    logic [WIDTH-1:0] inc;
    logic [WIDTH:0]   exp_q[$];
    int               total;
    int               bad;

    count_sampler #(
        .WIDTH  (32),
        .PERIOD (16),
        .DEPTH  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .count      (count),
        .enable     (enable),
        .clear      (clear),
`ifdef SAMPLER_MAXDELTA_EN
        .max_delta  (max_delta),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_delta  (out_delta),
        .out_wrap   (out_wrap),
        .level      (level),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance n clocks; count moves by inc just after every rising edge.
    task automatic clk_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            count = count + inc;
        end
    endtask

    task automatic expect_rec(input logic wrap, input logic [WIDTH-1:0] delta);
        exp_q.push_back({wrap, delta});
    endtask

    // Monitor: every handshake must match the oldest queued record.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop: got delta=0x%0h wrap=%0b with nothing queued",
                         out_delta, out_wrap);
            end else begin
                logic [WIDTH:0] e;
                e = exp_q.pop_front();
                chk("pop_delta", 64'(out_delta), 64'(e[WIDTH-1:0]));
                chk("pop_wrap",  64'(out_wrap),  64'(e[WIDTH]));
            end
        end
    end

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b0;
        count     = '0;
        inc       = 32'd1;
        enable    = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;

        // Reset values
        clk_n(3);
        chk("rst_valid",    64'(out_valid),  64'd0);
        chk("rst_delta",    64'(out_delta),  64'd0);
        chk("rst_wrap",     64'(out_wrap),   64'd0);
        chk("rst_level",    64'(level),      64'd0);
        chk("rst_overflow", 64'(overflow),   64'd0);
        chk("rst_drops",    64'(drop_count), 64'd0);
`ifdef SAMPLER_MAXDELTA_EN
        chk("rst_maxd",     64'(max_delta),  64'd0);
`endif
        rst = 1'b1;
        clk_n(2);

        // Basic: first record 33 clocks after enable, then every 16
        count     = '0;
        enable    = 1'b1;
        out_ready = 1'b1;
        expect_rec(1'b0, 32'd16);
        expect_rec(1'b0, 32'd16);
        expect_rec(1'b0, 32'd16);
        clk_n(32);
        chk("basic_not_yet", 64'(out_valid), 64'd0);
        clk_n(1);
        chk("basic_valid",   64'(out_valid), 64'd1);
        chk("basic_delta",   64'(out_delta), 64'd16);
        clk_n(32);

        // Enable dropped mid-period: no further push
        enable = 1'b0;
        clk_n(20);
        chk("idle_level", 64'(level),     64'd0);
        chk("idle_valid", 64'(out_valid), 64'd0);

        // Wrap: baseline lands at 0xFFFF_FFF8, next capture at 0x8
        count  = 32'hFFFF_FFE8;
        enable = 1'b1;
        expect_rec(1'b1, 32'd16);
        expect_rec(1'b0, 32'd16);
        clk_n(50);
`ifdef SAMPLER_MAXDELTA_EN
        chk("maxd_16", 64'(max_delta), 64'd16);
`endif

        // Overflow: 5 ticks with no consumer, fourth period runs at +2/clk
        out_ready = 1'b0;
        expect_rec(1'b0, 32'd16);
        expect_rec(1'b0, 32'd16);
        expect_rec(1'b0, 32'd16);
        expect_rec(1'b0, 32'd32);
        clk_n(46);
        inc = 32'd2;
        clk_n(16);
        inc = 32'd1;
        clk_n(17);
        chk("ovf_level",    64'(level),      64'd4);
        chk("ovf_flag",     64'(overflow),   64'd1);
        chk("ovf_drops",    64'(drop_count), 64'd1);
`ifdef SAMPLER_MAXDELTA_EN
        chk("maxd_32",      64'(max_delta),  64'd32);
`endif
        out_ready = 1'b1;
        clk_n(1);
        chk("drain_level3", 64'(level), 64'd3);
        clk_n(1);
        chk("drain_level2", 64'(level), 64'd2);
        clk_n(1);
        chk("drain_level1", 64'(level), 64'd1);
        clk_n(1);
        chk("drain_level0", 64'(level), 64'd0);

        // Full FIFO with push and pop in the same tick cycle
        out_ready = 1'b0;
        repeat (5) expect_rec(1'b0, 32'd16);
        clk_n(75);
        chk("full_level", 64'(level), 64'd4);
        out_ready = 1'b1;
        clk_n(1);
        chk("pp_level", 64'(level),      64'd4);
        chk("pp_drops", 64'(drop_count), 64'd1);
        clk_n(1);
        out_ready = 1'b0;
        chk("pre_clear_level", 64'(level), 64'd3);

        // Clear with three entries queued
        clear = 1'b1;
        clk_n(1);
        clear = 1'b0;
        exp_q.delete();
        chk("clr_level",    64'(level),      64'd0);
        chk("clr_valid",    64'(out_valid),  64'd0);
        chk("clr_overflow", 64'(overflow),   64'd0);
        chk("clr_drops",    64'(drop_count), 64'd0);
`ifdef SAMPLER_MAXDELTA_EN
        chk("clr_maxd",     64'(max_delta),  64'd0);
`endif
        // Period counter and baseline kept running through clear
        expect_rec(1'b0, 32'd16);
        clk_n(13);
        chk("post_clr_level0", 64'(level), 64'd0);
        clk_n(1);
        chk("post_clr_level1", 64'(level), 64'd1);
        out_ready = 1'b1;
        clk_n(1);

        // Build level=2 with overflow set, then reset mid-operation
        out_ready = 1'b0;
        repeat (4) expect_rec(1'b0, 32'd16);
        clk_n(79);
        chk("ovf2_level", 64'(level),      64'd4);
        chk("ovf2_flag",  64'(overflow),   64'd1);
        chk("ovf2_drops", 64'(drop_count), 64'd1);
        out_ready = 1'b1;
        clk_n(2);
        out_ready = 1'b0;
        chk("pre_rst_level", 64'(level), 64'd2);
        rst = 1'b0;
        clk_n(1);
        exp_q.delete();
        chk("mid_rst_valid",    64'(out_valid),  64'd0);
        chk("mid_rst_delta",    64'(out_delta),  64'd0);
        chk("mid_rst_level",    64'(level),      64'd0);
        chk("mid_rst_overflow", 64'(overflow),   64'd0);
        chk("mid_rst_drops",    64'(drop_count), 64'd0);
        rst = 1'b1;
        expect_rec(1'b0, 32'd16);
        clk_n(32);
        chk("rst_restart_not_yet", 64'(out_valid), 64'd0);
        clk_n(1);
        chk("rst_restart_valid", 64'(out_valid), 64'd1);
        chk("rst_restart_level", 64'(level),     64'd1);
        out_ready = 1'b1;
        clk_n(2);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
